// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder: turns a mnemonic request plus fields into a 32-bit
// MIPS instruction word. Each word is tagged with a sequential word address
// and buffered in a small output FIFO.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid/in_ready     request handshake
//   in_op                 mnemonic (0 NOP .. 15 J; 16-31 illegal)
//   in_rs/rt/rd/shamt     register and shift fields
//   in_imm, in_target     immediate/branch offset and jump target
//   out_valid/out_ready   FIFO head handshake
//   out_instr, out_addr   head word and its word address
//   err, err_cnt          illegal-request pulse and saturating count
module mips_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_shamt,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          err,
    output logic [7:0]    err_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Mnemonic codes
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_SLT  = 5'd5;
    localparam logic [4:0] OP_SLL  = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd7;
    localparam logic [4:0] OP_ANDI = 5'd8;
    localparam logic [4:0] OP_ORI  = 5'd9;
    localparam logic [4:0] OP_SLTI = 5'd10;
    localparam logic [4:0] OP_LW   = 5'd11;
    localparam logic [4:0] OP_SW   = 5'd12;
    localparam logic [4:0] OP_BEQ  = 5'd13;
    localparam logic [4:0] OP_BNE  = 5'd14;
    localparam logic [4:0] OP_J    = 5'd15;

    // Primary opcodes as seen by the control decoder
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_SLTI  = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_NOP   = 6'b111111;

    // R-type funct codes for the ALU control decoder
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    function automatic logic [31:0] r_word(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] sh,
        input logic [5:0] fn
    );
        return {OPC_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_word(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

    // Encoder
    logic [31:0] enc_word;
    logic        enc_illegal;

    always_comb begin
        enc_word    = 32'h0;
        enc_illegal = 1'b0;
        case (in_op)
            OP_NOP:  enc_word = {OPC_NOP, 26'h0};
            OP_ADD:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_ADD);
            OP_SUB:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SUB);
            OP_AND:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_AND);
            OP_OR:   enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_OR);
            OP_SLT:  enc_word = r_word(in_rs, in_rt, in_rd, 5'd0, FN_SLT);
            OP_SLL:  enc_word = r_word(in_rs, in_rt, in_rd, in_shamt, FN_SLL);
            OP_ADDI: enc_word = i_word(OPC_ADDI, in_rs, in_rt, in_imm);
            OP_ANDI: enc_word = i_word(OPC_ANDI, in_rs, in_rt, in_imm);
            OP_ORI:  enc_word = i_word(OPC_ORI, in_rs, in_rt, in_imm);
            OP_SLTI: enc_word = i_word(OPC_SLTI, in_rs, in_rt, in_imm);
            OP_LW:   enc_word = i_word(OPC_LW, in_rs, in_rt, in_imm);
            OP_SW:   enc_word = i_word(OPC_SW, in_rs, in_rt, in_imm);
            OP_BEQ:  enc_word = i_word(OPC_BEQ, in_rs, in_rt, in_imm);
            OP_BNE:  enc_word = i_word(OPC_BNE, in_rs, in_rt, in_imm);
            OP_J:    enc_word = {OPC_J, in_target};
            default: enc_illegal = 1'b1;
        endcase
    end

    // State
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   out_instr_q, out_instr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [31:0]   mem_instr_q [DEPTH];
    logic [AW-1:0] mem_addr_q  [DEPTH];

    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_after_pop;

    // in_ready is based on the registered count only, so a pop in the
    // same cycle never frees room for a push into a full FIFO.
    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !enc_illegal;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        addr_d          = addr_q;
        count_after_pop = count_q - CW'(pop);
        count_d         = count_after_pop + CW'(push);
        out_instr_d     = out_instr_q;
        out_addr_d      = out_addr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            addr_d   = addr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // The head is mirrored in registers so it holds its last value
        // once the FIFO drains. If nothing older survives the pop, the
        // new head is the word being pushed this cycle.
        if (count_d != '0) begin
            if (count_after_pop == '0) begin
                out_instr_d = enc_word;
                out_addr_d  = addr_q;
            end else begin
                out_instr_d = mem_instr_q[rd_ptr_d];
                out_addr_d  = mem_addr_q[rd_ptr_d];
            end
        end
    end

    always_comb begin
        err_d     = accept && enc_illegal;
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= enc_word;
            mem_addr_q[wr_ptr_q]  <= addr_q;
        end
    end

    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Reverse direction of the main/ALU control decode path: turns a symbolic instruction request (mnemonic code plus fields) into a 32-bit MIPS instruction word.
- Each word carries the exact opcode/funct values the control decoder consumes.
- Sits between a program loader (testbench, UART loader or boot sequencer) and instruction memory.
- Buffers encoded words in a small FIFO, tags each with a sequential word address, and uses valid/ready handshakes on both sides.

Parameters:
- DEPTH, 4, output FIFO depth in words; power of two, at least 2.
- AW, 8, width of the word-address counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  5  mnemonic code: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 SLL, 7 ADDI, 8 ANDI, 9 ORI, 10 SLTI, 11 LW, 12 SW, 13 BEQ, 14 BNE, 15 J; codes 16-31 are illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  encoded word.
- out_addr  out  AW  word address of the head entry.
- err  out  1  one-cycle pulse for an illegal request.
- err_cnt  out  8  saturating count of illegal requests.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied; out_valid=0.
  - out_instr=0, out_addr=0, err=0, err_cnt=0.
  - Address counter=0; in_ready=1 once reset is released.
- Input handshake:
  - A request is accepted on a clk edge when in_valid and in_ready are both 1.
  - in_ready = !full. It is registered-full based, so a pop in the same cycle does not allow a push when full.
- Encoding (combinational on the inputs, captured at acceptance):
  - R-type (codes 1-6): {6'b000000, rs, rt, rd, shamt', funct}.
  - funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000.
  - shamt' = in_shamt for SLL only; forced to 0 otherwise.
  - I-type: {opcode, rs, rt, imm}.
  - I-type opcodes: ADDI 001000, ANDI 001100, ORI 001101, SLTI 001011, LW 100011, SW 101011, BEQ 000100, BNE 000101.
  - J: {6'b000010, target}.
  - NOP: 32'hFC000000 ({6'b111111, 26'b0}); all fields ignored.
  - Fields unused by a format are ignored.
- Legal accept:
  - Word pushed into the FIFO with the current address counter value, then the counter increments.
  - The counter wraps from 2^AW-1 to 0.
  - Latency: the word is visible at out_instr/out_valid on the cycle after acceptance when the FIFO was empty.
- Illegal accept (code 16-31):
  - The handshake completes and nothing is pushed.
  - The address counter is unchanged.
  - err=1 for exactly the next cycle; err_cnt increments and saturates at 255.
- Output handshake:
  - Pop when out_valid and out_ready are both 1.
  - out_instr/out_addr must stay stable while out_valid=1 and out_ready=0.
  - When out_valid=0, out_instr/out_addr hold their last value.
- Simultaneous push and pop (not full):
  - Both occur and the count is unchanged.
  - Empty FIFO with push and out_ready=1: no bypass; the word appears next cycle.
- Full FIFO: in_ready=0 and in_valid requests are held off; no data is lost or overwritten.
- Reset asserted mid-operation: all state clears immediately; in-flight words are discarded.
- Ordering: strict FIFO, with addresses strictly sequential modulo 2^AW across legal requests.

Test Plan:
- Reset, then ADD rs=1 rt=2 rd=3 shamt=7, out_ready=1 -> out_instr=0x00221820 (shamt forced 0), out_addr=0, out_valid one cycle after accept.
- LW rs=29 rt=8 imm=0x0004, then SLL rt=2 rd=4 shamt=3, then J target=0x0000010 -> 0x8FA80004 @0, 0x000220C0 @1, 0x08000010 @2, in order.
- NOP with random fields -> 0xFC000000; decoder fed out_instr[31:26] produces RegWrite=0, MemWrite=0.
- out_ready=0, push 5 requests with DEPTH=4 -> in_ready=0 after the 4th accept; the 5th is held; out_instr stable. Release out_ready -> 5 words with addresses 0-4.
- in_op=20 mid-stream between two ADDIs -> err pulses once, err_cnt=1; the ADDIs get consecutive addresses with no gap.
- AW=8, issue 257 legal requests -> address sequence wraps 255->0. Assert rst_n low while the FIFO holds 3 words -> out_valid=0 immediately, err_cnt=0, next word has out_addr=0.
